axi4_mul_slave: RTL
===================

AXI4_MUL_SLAVE -- requirements
Module: axi4_mul_slave

Interface
REQ-001 SHALL have parameter SZ, default 32, operand width in bits.
REQ-002 SHALL have parameter ASZ, default 2, address width.
REQ-003 SHALL have parameter DSZ, default 8, data beat width; SZ/DSZ = 4 beats per operand.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port _rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have AW ports: awaddr in ASZ, awvalid in 1, awready out 1.
REQ-007 SHALL have W ports: wdata in DSZ, wvalid in 1, wready out 1, wlast in 1.
REQ-008 SHALL have B ports: bresp out 1 (1 = ok), bvalid out 1, bready in 1.
REQ-009 SHALL have AR ports: araddr in ASZ, arvalid in 1, arready out 1.
REQ-010 SHALL have R ports: rdata out DSZ, rvalid out 1, rready in 1, rlast out 1, rresp out 1 (1 = ok).
REQ-011 SHALL have port busy, output, 1: multiplier running or start pending.

Function
REQ-012 SHALL hold operand registers opa, opb (SZ each); awaddr 0 selects opa, 1 selects opb; other addresses are invalid.
REQ-013 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); all outputs registered.
REQ-014 W_IDLE -> W_DATA on awvalid&awready; latch awaddr; clear beat counter.
REQ-015 In W_DATA, each wvalid&wready SHALL store wdata into staging byte [beat], little-endian (beat 0 = bits 7:0); beats beyond 3 are discarded.
REQ-016 W_DATA -> W_RESP on the beat with wlast=1.
REQ-017 bresp SHALL be 1 only if address valid and wlast arrived on exactly beat 3; only then is staging copied into the selected operand (commit).
REQ-018 On bad burst (invalid address, early or late wlast) operands SHALL remain unchanged and bresp=0.
REQ-019 W_RESP -> W_IDLE on bvalid&bready.
REQ-020 Each commit SHALL start the multiplier if idle, else set a pending flag that restarts it on completion.
REQ-021 Multiplier SHALL be unsigned shift-add, one partial product per cycle; done exactly SZ cycles after start; 2*SZ-bit product register updated in the done cycle.
REQ-022 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 in R_IDLE only while busy=0.
REQ-023 On arvalid&arready SHALL snapshot product, set rresp=(araddr==0), clear index, enter R_DATA.
REQ-024 In R_DATA rvalid=1, rdata=snapshot byte[index], rlast=(index==2*SZ/DSZ-1); index increments on rvalid&rready.
REQ-025 Handshake with rlast=1 SHALL return to R_IDLE; invalid-address reads still return 8 beats of snapshot data.
REQ-026 Write and read FSMs SHALL be independent; simultaneous awvalid and arvalid both accepted in the same cycle.
REQ-027 Handshake outputs SHALL hold stable until accepted.

Reset
REQ-028 On _rst low: opa, opb, product, staging, counters, pending = 0; FSMs idle; awready=1, arready=1, wready, bvalid, bresp, rvalid, rlast, rresp, rdata, busy = 0.
REQ-029 Reset mid-burst or mid-multiply SHALL abort with no commit and no response.

Structure
REQ-030 Shared package axi4_pkg SHALL hold write/read FSM state enums and default SZ/ASZ/DSZ constants.
REQ-031 Multiplier SHALL be sub-module mul_seq (start, a, b, busy, done, product).

Verification
REQ-032 Write opa=3, opb=5, wait busy=0, read addr 0 -> beats 0x0F,0,0,0,0,0,0,0; rlast on beat 7; rresp=1; both bresp=1.
REQ-033 opa=opb=0xFFFFFFFF -> product 0xFFFFFFFE00000001, beats 01,00,00,00,FE,FF,FF,FF.
REQ-034 Write awaddr=2 data 0xAA x4 -> bresp=0; subsequent read unchanged.
REQ-035 wlast on beat 1 to addr 0 -> bresp=0, opa unchanged, FSM back in W_IDLE after bready.
REQ-036 arvalid held during compute -> arready low for exactly 32 cycles after commit, then read returns new product.
REQ-037 _rst low during W_DATA beat 2 -> all outputs at reset values, opa unchanged (0), next full burst accepted with bresp=1.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared types and default widths for the AXI4 multiplier slave.
// Both FSM state encodings live here so the top and any checker agree on them.
package axi4_pkg;
    localparam int SZ_DEF  = 32;
    localparam int ASZ_DEF = 2;
    localparam int DSZ_DEF = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;
endpackage

// File: rtl/mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, product
// register and done pulse land exactly SZ cycles after start.
module mul_seq
    import axi4_pkg::*;
#(
    parameter int SZ = SZ_DEF
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          start,
    input  logic [SZ-1:0] a,
    input  logic [SZ-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [2*SZ-1:0] product
);
    localparam int CW = $clog2(SZ);

    logic [2*SZ-1:0] a_q, a_d, acc_q, acc_d, product_q, product_d, pp;
    logic [SZ-1:0]   b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        product_d = product_q;
        done_d    = 1'b0;
        pp        = b_q[0] ? a_q : '0;
        if (start) begin
            a_d    = {{SZ{1'b0}}, a};
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_q + pp;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            // Last partial product: publish the sum directly so the product
            // register updates in the same cycle done is raised.
            if (cnt_q == CW'(SZ - 1)) begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                product_d = acc_q + pp;
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: rtl/axi4_mul_slave.sv
// AXI4-style slave: 4-beat bursts load operands opa/opb, each good burst
// (re)starts a sequential multiply, 8-beat reads return the product bytes.
module axi4_mul_slave
    import axi4_pkg::*;
#(
    parameter int SZ  = SZ_DEF,
    parameter int ASZ = ASZ_DEF,
    parameter int DSZ = DSZ_DEF
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [ASZ-1:0] awaddr,
    input  logic           awvalid,
    output logic           awready,
    input  logic [DSZ-1:0] wdata,
    input  logic           wvalid,
    output logic           wready,
    input  logic           wlast,
    output logic           bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [ASZ-1:0] araddr,
    input  logic           arvalid,
    output logic           arready,
    output logic [DSZ-1:0] rdata,
    output logic           rvalid,
    input  logic           rready,
    output logic           rlast,
    output logic           rresp,
    output logic           busy
);
    localparam int NB = SZ / DSZ;
    localparam int RB = 2 * SZ / DSZ;
    localparam int BW = $clog2(NB) + 1;
    localparam int IW = $clog2(RB);

    w_state_e        w_state_q, w_state_d;
    r_state_e        r_state_q, r_state_d;
    logic            awready_q, awready_d, wready_q, wready_d;
    logic            bvalid_q, bvalid_d, bresp_q, bresp_d;
    logic [ASZ-1:0]  addr_q, addr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SZ-1:0]   stage_q, stage_d, opa_q, opa_d, opb_q, opb_d;
    logic            pending_q, pending_d;
    logic            rvalid_q, rvalid_d, rlast_q, rlast_d, rresp_q, rresp_d;
    logic [DSZ-1:0]  rdata_q, rdata_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2*SZ-1:0] snap_q, snap_d;
    logic            commit, addr_ok, mul_start, mul_busy, mul_done;
    logic [2*SZ-1:0] mul_product;

    assign addr_ok = (addr_q == '0) || (addr_q == ASZ'(1));
    assign busy    = mul_busy || pending_q;
    assign arready = (r_state_q == R_IDLE) && !busy;

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        stage_d   = stage_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid && awready_q) begin
                addr_d    = awaddr;
                beat_d    = '0;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid && wready_q) begin
                // Counter saturates at NB so over-long bursts stay detectable.
                if (beat_q < BW'(NB)) begin
                    stage_d[beat_q*DSZ +: DSZ] = wdata;
                    beat_d = beat_q + 1'b1;
                end
                if (wlast) begin
                    commit    = addr_ok && (beat_q == BW'(NB - 1));
                    bresp_d   = commit;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (bvalid_q && bready) begin
                bvalid_d  = 1'b0;
                bresp_d   = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit && addr_q == '0)     opa_d = stage_d;
        if (commit && addr_q == ASZ'(1)) opb_d = stage_d;
        // A commit during a multiply is remembered and replayed on done,
        // picking up whatever operands are current at that point.
        mul_start = (commit && !mul_busy) || (pending_q && mul_done);
        pending_d = mul_start ? 1'b0 : (commit ? 1'b1 : pending_q);
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        case (r_state_q)
            R_IDLE: if (arvalid && arready) begin
                snap_d    = mul_product;
                rresp_d   = (araddr == '0);
                idx_d     = '0;
                rvalid_d  = 1'b1;
                rdata_d   = mul_product[DSZ-1:0];
                rlast_d   = (RB == 1);
                r_state_d = R_DATA;
            end
            R_DATA: if (rvalid_q && rready) begin
                if (rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    rresp_d   = 1'b0;
                    rdata_d   = '0;
                    r_state_d = R_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    rdata_d = snap_q[idx_d*DSZ +: DSZ];
                    rlast_d = (idx_d == IW'(RB - 1));
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
            addr_q    <= '0;
            beat_q    <= '0;
            stage_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            pending_q <= 1'b0;
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 1'b0;
            rdata_q   <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            stage_q   <= stage_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            pending_q <= pending_d;
            r_state_q <= r_state_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
        end
    end

    mul_seq #(.SZ(SZ)) u_mul (
        .clk     (clk),
        ._rst    (_rst),
        .start   (mul_start),
        .a       (opa_d),
        .b       (opb_d),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
endmodule
